// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   exc_state_e : exception drain/flush/recover FSM states.
//   STG_*       : stage indices for the 6-register pipeline configuration.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_WAIT,
    EXC_FLUSH,
    EXC_RECOVER
  } exc_state_e;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_II  = 1;
  localparam int unsigned STG_ID2 = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : count this cycle (ignored once all ones)
//   clr_i    : synchronous clear, wins over inc_i
//   cnt_o    : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller: per-register stall/flush generation for an N-register
// in-order pipeline (register 0 = PC, register N-1 = writeback).
//   clk, rst        : clock, asynchronous active-high reset
//   stall_req       : per-stage "cannot advance" requests
//   flush_req       : per-stage redirect requests (younger work is wrong)
//   exc_req         : exception/eret commit request from the oldest stage
//   cnt_clr         : synchronous clear of both perf counters
//   stall_o/flush_o : hold / bubble-load controls per register
//   redirect_o      : PC redirect pulse, redirect_src_o = causing stage
//   exc_busy_o      : exception FSM not idle
//   stall_cnt_o     : cycles with PC held, flush_cnt_o : redirect pulses
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N           = 6,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned IDX_W       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     stall_req,
  input  logic [N-1:0]     flush_req,
  input  logic             exc_req,
  input  logic             cnt_clr,
  output logic [N-1:0]     stall_o,
  output logic [N-1:0]     flush_o,
  output logic             redirect_o,
  output logic [IDX_W-1:0] redirect_src_o,
  output logic             exc_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned RcW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC + 1) : 1;

  exc_state_e     state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [RcW-1:0] rec_q, rec_d;

  logic [N-1:0]     stall_prop;  // older stall holds every younger register
  logic [N-1:0]     bubble;      // bubble below a held register
  logic [N-1:0]     eff;         // redirects allowed to act this cycle
  logic [N-1:0]     le_mask;     // bit k set when k <= oldest effective redirect
  logic [IDX_W-1:0] j_idx;

  always_comb begin
    bubble = '0;
    j_idx  = '0;
    for (int r = 0; r < N; r++) begin
      stall_prop[r] = |(stall_req >> r);
    end
    for (int r = 0; r < N - 1; r++) begin
      bubble[r+1] = stall_prop[r] & ~stall_prop[r+1];
    end
    eff = (flush_req | pending_q) & ~stall_prop;
    for (int r = 0; r < N; r++) begin
      le_mask[r] = |(eff >> r);
      if (eff[r]) begin
        j_idx = IDX_W'(r);  // ascending scan leaves the oldest
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    rec_d          = rec_q;
    stall_o        = '0;
    flush_o        = '0;
    redirect_o     = 1'b0;
    redirect_src_o = '0;

    unique case (state_q)
      EXC_IDLE: begin
        if (exc_req) begin
          stall_o = '1;
          state_d = (|stall_req) ? EXC_WAIT : EXC_FLUSH;
        end else begin
          stall_o   = stall_prop;
          flush_o   = bubble;
          // Requests from a held stage are parked until that stage moves.
          pending_d = pending_q | (flush_req & stall_prop);
          if (|eff) begin
            flush_o         = bubble | {le_mask[N-1:1], 1'b0};
            stall_o[STG_PC] = 1'b0;
            redirect_o      = 1'b1;
            redirect_src_o  = j_idx;
            pending_d       = pending_d & ~le_mask;
          end
        end
      end
      EXC_WAIT: begin
        stall_o = '1;
        if (stall_req == '0) begin
          state_d = EXC_FLUSH;
        end
      end
      EXC_FLUSH: begin
        flush_o        = {{(N-1){1'b1}}, 1'b0};
        redirect_o     = 1'b1;
        redirect_src_o = IDX_W'(N - 1);
        pending_d      = '0;
        rec_d          = RcW'(RECOVER_CYC);
        state_d        = (RECOVER_CYC > 0) ? EXC_RECOVER : EXC_IDLE;
      end
      EXC_RECOVER: begin
        stall_o         = stall_prop;
        stall_o[STG_PC] = 1'b1;
        flush_o         = bubble;
        flush_o[1]      = 1'b1;
        if (rec_q == RcW'(1)) begin
          state_d = EXC_IDLE;
        end else begin
          rec_d = rec_q - RcW'(1);
        end
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EXC_IDLE;
      pending_q <= '0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rec_q     <= rec_d;
    end
  end

  assign exc_busy_o = (state_q != EXC_IDLE);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(stall_o[STG_PC]),
    .clr_i(cnt_clr),
    .cnt_o(stall_cnt_o)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(redirect_o),
    .clr_i(cnt_clr),
    .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen (N=6, RECOVER_CYC=2): directed scenarios plus a randomized
// run against a cycle-level reference model; a second instance with 4-bit counters
// covers saturation.
module tb_pipe_ctrl_gen;

  localparam int N   = 6;
  localparam int REC = 2;
  localparam int S_IDLE = 0, S_WAIT = 1, S_FLUSH = 2, S_RECOVER = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall_req, flush_req;
  logic       exc_req, cnt_clr;

  logic [5:0]  stall_o, flush_o;
  logic        redirect_o, busy;
  logic [2:0]  src;
  logic [31:0] scnt, fcnt;

  logic [5:0]  s2_stall, s2_flush;
  logic        s2_redir, s2_busy;
  logic [2:0]  s2_src;
  logic [3:0]  s2_scnt, s2_fcnt;

  pipe_ctrl_gen #(.N(6), .RECOVER_CYC(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .exc_req(exc_req), .cnt_clr(cnt_clr), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_src_o(src), .exc_busy_o(busy),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipe_ctrl_gen #(.N(6), .RECOVER_CYC(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .exc_req(exc_req), .cnt_clr(cnt_clr), .stall_o(s2_stall), .flush_o(s2_flush),
    .redirect_o(s2_redir), .redirect_src_o(s2_src), .exc_busy_o(s2_busy),
    .stall_cnt_o(s2_scnt), .flush_cnt_o(s2_fcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_state, m_rec, m_j;
  logic [5:0] m_pend, raw_stall;
  longint     m_scnt, m_fcnt;
  logic [5:0] e_stall, e_flush;
  logic       e_redir, e_busy;
  int         e_src;

  task automatic model_reset();
    m_state = S_IDLE; m_rec = 0; m_pend = '0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_comb();
    e_stall = '0; e_flush = '0; e_redir = 1'b0; e_src = 0; m_j = -1;
    for (int r = 0; r < N; r++) begin
      raw_stall[r] = 1'b0;
      for (int k = r; k < N; k++) if (stall_req[k]) raw_stall[r] = 1'b1;
    end
    case (m_state)
      S_IDLE: begin
        if (exc_req) e_stall = '1;
        else begin
          e_stall = raw_stall;
          for (int r = 0; r < N - 1; r++) if (raw_stall[r] && !raw_stall[r+1]) e_flush[r+1] = 1;
          for (int r = 0; r < N; r++) if ((flush_req[r] || m_pend[r]) && !raw_stall[r]) m_j = r;
          if (m_j >= 0) begin
            for (int k = 1; k <= m_j; k++) e_flush[k] = 1'b1;
            e_stall[0] = 1'b0; e_redir = 1'b1; e_src = m_j;
          end
        end
      end
      S_WAIT: e_stall = '1;
      S_FLUSH: begin
        for (int k = 1; k < N; k++) e_flush[k] = 1'b1;
        e_redir = 1'b1; e_src = N - 1;
      end
      default: begin
        e_stall = raw_stall; e_stall[0] = 1'b1;
        for (int r = 0; r < N - 1; r++) if (raw_stall[r] && !raw_stall[r+1]) e_flush[r+1] = 1;
        e_flush[1] = 1'b1;
      end
    endcase
    e_busy = (m_state != S_IDLE);
  endtask

  task automatic model_seq();
    if (cnt_clr) begin
      m_scnt = 0; m_fcnt = 0;
    end else begin
      m_scnt += e_stall[0]; m_fcnt += e_redir;
    end
    case (m_state)
      S_IDLE: begin
        if (exc_req) m_state = (stall_req != 0) ? S_WAIT : S_FLUSH;
        else begin
          for (int r = 0; r < N; r++) if (flush_req[r] && raw_stall[r]) m_pend[r] = 1'b1;
          for (int k = 0; k <= m_j; k++) m_pend[k] = 1'b0;
        end
      end
      S_WAIT: if (stall_req == 0) m_state = S_FLUSH;
      S_FLUSH: begin
        m_pend = '0;
        if (REC > 0) begin m_state = S_RECOVER; m_rec = REC; end
        else m_state = S_IDLE;
      end
      default: if (m_rec == 1) m_state = S_IDLE; else m_rec--;
    endcase
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic [5:0] s, input logic [5:0] f, input logic e, input logic c);
    stall_req = s; flush_req = f; exc_req = e; cnt_clr = c;
    model_comb();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_req = '0; flush_req = '0; exc_req = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({stall_o, flush_o, redirect_o, busy} !== 14'd0 || scnt !== 0 || fcnt !== 0) begin
      errors++;
      $display("FAIL reset_outputs got st=%b fl=%b rd=%b bz=%b sc=%0d fc=%0d want all 0",
               stall_o, flush_o, redirect_o, busy, scnt, fcnt);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if ({stall_o, flush_o, redirect_o, busy} !== 14'd0) begin
      errors++;
      $display("FAIL idle_outputs got st=%b fl=%b rd=%b bz=%b want 0", stall_o, flush_o,
               redirect_o, busy);
    end
    tick();
  endtask

  task automatic test_stall_prop();
    drive(6'b0, 6'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(6'b001000, 6'b0, 1'b0, 1'b0);
      checks++;
      if (stall_o !== 6'b001111 || flush_o !== 6'b010000 || redirect_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_prop got st=%b fl=%b rd=%b want 001111 010000 0", stall_o,
                 flush_o, redirect_o);
      end
      checks++;
      if (scnt !== 32'(i)) begin
        errors++; $display("FAIL stall_cnt_inc got %0d want %0d", scnt, i);
      end
      tick();
    end
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (scnt !== 32'd3) begin errors++; $display("FAIL stall_cnt_3 got %0d want 3", scnt); end
    tick();
  endtask

  task automatic test_latched_flush();
    drive(6'b0, 6'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 2; i++) begin
      drive(6'b010000, 6'b001000, 1'b0, 1'b0);
      checks++;
      if (stall_o !== 6'b011111 || flush_o !== 6'b100000 || redirect_o !== 1'b0) begin
        errors++;
        $display("FAIL latch_hold got st=%b fl=%b rd=%b want 011111 100000 0", stall_o,
                 flush_o, redirect_o);
      end
      tick();
    end
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (flush_o !== 6'b001110 || redirect_o !== 1'b1 || src !== 3'd3 || stall_o !== 6'b0) begin
      errors++;
      $display("FAIL latch_replay got fl=%b rd=%b src=%0d st=%b want 001110 1 3 000000",
               flush_o, redirect_o, src, stall_o);
    end
    tick();
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (redirect_o !== 1'b0 || fcnt !== 32'd1) begin
      errors++;
      $display("FAIL latch_cleared got rd=%b fc=%0d want 0 1", redirect_o, fcnt);
    end
    tick();
  endtask

  task automatic test_multi_flush();
    drive(6'b0, 6'b0, 1'b0, 1'b1); tick();
    drive(6'b0, 6'b010100, 1'b0, 1'b0);
    checks++;
    if (flush_o !== 6'b011110 || redirect_o !== 1'b1 || src !== 3'd4 || stall_o !== 6'b0) begin
      errors++;
      $display("FAIL oldest_wins got fl=%b rd=%b src=%0d st=%b want 011110 1 4 000000",
               flush_o, redirect_o, src, stall_o);
    end
    tick();
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (fcnt !== 32'd1 || redirect_o !== 1'b0) begin
      errors++; $display("FAIL flush_cnt_1 got fc=%0d rd=%b want 1 0", fcnt, redirect_o);
    end
    tick();
  endtask

  task automatic test_exception();
    int busy_cycles;
    busy_cycles = 0;
    drive(6'b0, 6'b0, 1'b0, 1'b1); tick();
    drive(6'b100000, 6'b000100, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 6'b111111 || flush_o !== 6'b0 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_entry got st=%b fl=%b rd=%b want 111111 000000 0", stall_o, flush_o,
               redirect_o);
    end
    busy_cycles += busy;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive((i < 2) ? 6'b100000 : 6'b0, 6'b0, 1'b1, 1'b0);
      checks++;
      if (stall_o !== 6'b111111 || busy !== 1'b1 || redirect_o !== 1'b0) begin
        errors++;
        $display("FAIL exc_wait got st=%b bz=%b rd=%b want 111111 1 0", stall_o, busy,
                 redirect_o);
      end
      busy_cycles += busy;
      tick();
    end
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (flush_o !== 6'b111110 || stall_o !== 6'b0 || redirect_o !== 1'b1 || src !== 3'd5) begin
      errors++;
      $display("FAIL exc_flush got fl=%b st=%b rd=%b src=%0d want 111110 000000 1 5", flush_o,
               stall_o, redirect_o, src);
    end
    busy_cycles += busy;
    tick();
    drive(6'b0, 6'b000100, 1'b0, 1'b0);
    checks++;
    if (stall_o !== 6'b000001 || flush_o !== 6'b000010 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL recover_1 got st=%b fl=%b rd=%b want 000001 000010 0", stall_o, flush_o,
               redirect_o);
    end
    busy_cycles += busy;
    tick();
    drive(6'b001000, 6'b000100, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 6'b001111 || flush_o !== 6'b010010 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL recover_2 got st=%b fl=%b rd=%b want 001111 010010 0", stall_o, flush_o,
               redirect_o);
    end
    busy_cycles += busy;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(6'b0, 6'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || redirect_o !== 1'b0 || stall_o !== 6'b0) begin
        errors++;
        $display("FAIL exc_done got bz=%b rd=%b st=%b want 0 0 000000", busy, redirect_o,
                 stall_o);
      end
      tick();
    end
    checks++;
    if (busy_cycles != 6 || scnt !== 32'd6 || fcnt !== 32'd1) begin
      errors++;
      $display("FAIL exc_totals got busy=%0d sc=%0d fc=%0d want 6 6 1", busy_cycles, scnt, fcnt);
    end
  endtask

  task automatic test_saturation();
    drive(6'b0, 6'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 20; i++) begin
      drive(6'b000001, 6'b0, 1'b0, 1'b0); tick();
    end
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (s2_scnt !== 4'd15 || scnt !== 32'd20) begin
      errors++; $display("FAIL saturate got s4=%0d s32=%0d want 15 20", s2_scnt, scnt);
    end
    tick();
    drive(6'b000001, 6'b0, 1'b0, 1'b1); tick();
    drive(6'b0, 6'b0, 1'b0, 1'b0);
    checks++;
    if (s2_scnt !== 4'd0 || scnt !== 32'd0) begin
      errors++; $display("FAIL clr_priority got s4=%0d s32=%0d want 0 0", s2_scnt, scnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_fsm();
    drive(6'b001000, 6'b000100, 1'b0, 1'b0);
    checks++;
    if (redirect_o !== 1'b0) begin
      errors++; $display("FAIL park_pending got rd=%b want 0", redirect_o);
    end
    tick();
    drive(6'b001000, 6'b0, 1'b1, 1'b0); tick();
    drive(6'b001000, 6'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || stall_o !== 6'b111111) begin
      errors++; $display("FAIL in_wait got bz=%b st=%b want 1 111111", busy, stall_o);
    end
    #1;
    stall_req = '0; flush_req = '0; exc_req = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({stall_o, flush_o, redirect_o, busy} !== 14'd0 || scnt !== 0) begin
      errors++;
      $display("FAIL async_reset got st=%b fl=%b rd=%b bz=%b sc=%0d want 0", stall_o, flush_o,
               redirect_o, busy, scnt);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'b0, 6'b0, 1'b0, 1'b0);
      checks++;
      if (redirect_o !== 1'b0 || flush_o !== 6'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_replay got rd=%b fl=%b bz=%b want 0", redirect_o, flush_o, busy);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [5:0] s, f;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < N; r++) begin
        s[r] = ($urandom_range(9) == 0);
        f[r] = ($urandom_range(6) == 0);
      end
      drive(s, f, ($urandom_range(30) == 0), ($urandom_range(60) == 0));
      checks++;
      if (stall_o !== e_stall || flush_o !== e_flush || redirect_o !== e_redir
          || busy !== e_busy) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got st=%b fl=%b rd=%b bz=%b want %b %b %b %b", n,
                 stall_o, flush_o, redirect_o, busy, e_stall, e_flush, e_redir, e_busy);
      end
      if (e_redir) begin
        checks++;
        if (src !== 3'(e_src)) begin
          errors++; $display("FAIL rand_src cyc %0d got %0d want %0d", n, src, e_src);
        end
      end
      checks++;
      if (scnt !== 32'(m_scnt) || fcnt !== 32'(m_fcnt)
          || s2_scnt !== 4'((m_scnt > 15) ? 15 : m_scnt)
          || s2_fcnt !== 4'((m_fcnt > 15) ? 15 : m_fcnt)) begin
        errors++;
        $display("FAIL rand_cnt cyc %0d got %0d %0d %0d %0d want %0d %0d (4b sat)", n, scnt,
                 fcnt, s2_scnt, s2_fcnt, m_scnt, m_fcnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stall_prop();
    test_latched_flush();
    test_multi_flush();
    test_exception();
    test_saturation();
    test_reset_mid_fsm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
